// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite fetch (during hblank) and registered pixel serialiser (during active video).
// Optional sticky collision output is built only when SPRITE_COLLISION_EN is defined.
module sprite_line_fetcher #(
    parameter int NUM_SPRITES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hblank_start,
    input  logic [9:0]               next_line,
    input  logic                     video_active,
    input  logic [9:0]               pixel_x,
    input  logic [NUM_SPRITES-1:0]   sprite_en,
    input  logic [NUM_SPRITES*10-1:0] sprite_x,
    input  logic [NUM_SPRITES*10-1:0] sprite_y,
    input  logic [NUM_SPRITES*4-1:0] sprite_id,
    input  logic [NUM_SPRITES*2-1:0] sprite_orient,
    output logic [3:0]               rom_sprite_ID,
    output logic [1:0]               rom_orientation,
    output logic [2:0]               rom_line_index,
    input  logic [7:0]               rom_data,
    output logic                     pixel_on,
    output logic [3:0]               pixel_sprite_id,
    output logic                     fetch_busy,
    output logic                     fetch_done
`ifdef SPRITE_COLLISION_EN
    ,
    output logic                     collision
`endif
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [9:0]         r_line;

    // Unpacked views of the live sprite table
    logic [9:0]         w_tab_x      [NUM_SPRITES];
    logic [9:0]         w_tab_y      [NUM_SPRITES];
    logic [3:0]         w_tab_id     [NUM_SPRITES];
    logic [1:0]         w_tab_orient [NUM_SPRITES];

    // Line buffer
    logic [NUM_SPRITES-1:0] r_valid;
    logic [7:0]         r_slot_row [NUM_SPRITES];
    logic [9:0]         r_slot_x   [NUM_SPRITES];
    logic [3:0]         r_slot_id  [NUM_SPRITES];

    logic [10:0]        w_dy;
    logic               w_hit;
    logic               w_last;

    logic [10:0]        w_dx     [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_opaque;
    logic               w_pix_on;
    logic [3:0]         w_pix_id;

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_tab_x[i]      = sprite_x[i*10 +: 10];
            w_tab_y[i]      = sprite_y[i*10 +: 10];
            w_tab_id[i]     = sprite_id[i*4 +: 4];
            w_tab_orient[i] = sprite_orient[i*2 +: 2];
        end
    end

    assign w_last = (r_idx == IDX_W'(NUM_SPRITES - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            if (hblank_start) begin
                r_line <= next_line;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        if (hblank_start) begin
            w_state_next = S_SCAN;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_IDLE;
                S_SCAN: begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Zero-extended subtraction: a sprite starting below the line sets bit 10 and never hits.
    assign w_dy  = {1'b0, r_line} - {1'b0, w_tab_y[r_idx]};
    assign w_hit = (r_state == S_SCAN) && sprite_en[r_idx] && (w_dy[10:3] == '0);

    always_comb begin
        rom_sprite_ID   = 4'hF;
        rom_orientation = 2'd0;
        rom_line_index  = 3'd0;
        if (r_state == S_SCAN) begin
            rom_sprite_ID   = w_tab_id[r_idx];
            rom_orientation = w_tab_orient[r_idx];
            rom_line_index  = w_dy[2:0];
        end
    end

    assign fetch_busy = (r_state == S_SCAN);
    assign fetch_done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (hblank_start) begin
            r_valid <= '0;
        end else if (w_hit) begin
            r_valid[r_idx] <= 1'b1;
        end
    end

    // NOTE: slot payload is not reset; it is never observed unless its valid bit is set.
    always_ff @(posedge clk) begin
        if (!hblank_start && w_hit) begin
            r_slot_row[r_idx] <= rom_data;
            r_slot_x[r_idx]   <= w_tab_x[r_idx];
            r_slot_id[r_idx]  <= w_tab_id[r_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_dx[i]     = {1'b0, pixel_x} - {1'b0, r_slot_x[i]};
            w_opaque[i] = r_valid[i] && (w_dx[i][10:3] == '0)
                          && !r_slot_row[i][3'd7 - w_dx[i][2:0]];
        end
    end

    // Walk from the highest slot down so the lowest opaque index is the one left standing.
    always_comb begin
        w_pix_on = 1'b0;
        w_pix_id = 4'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_pix_on = 1'b1;
                w_pix_id = r_slot_id[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_on        <= 1'b0;
            pixel_sprite_id <= 4'd0;
        end else begin
            pixel_on        <= video_active && w_pix_on;
            pixel_sprite_id <= video_active ? w_pix_id : 4'd0;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [3:0] w_opaque_cnt;

    always_comb begin
        w_opaque_cnt = 4'd0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_opaque_cnt = w_opaque_cnt + {3'd0, w_opaque[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
        end else if (video_active && (w_opaque_cnt >= 4'd2)) begin
            collision <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench for sprite_line_fetcher: directed tables, multi-cycle corner sequences,
// and randomized sprite tables compared against a plain-arithmetic line/pixel model.
module tb_sprite_line_fetcher;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           hblank_start;
    logic [9:0]     next_line;
    logic           video_active;
    logic [9:0]     pixel_x;
    logic [N-1:0]   sprite_en;
    logic [N*10-1:0] sprite_x;
    logic [N*10-1:0] sprite_y;
    logic [N*4-1:0] sprite_id;
    logic [N*2-1:0] sprite_orient;
    logic [3:0]     rom_sprite_ID;
    logic [1:0]     rom_orientation;
    logic [2:0]     rom_line_index;
    logic [7:0]     rom_data;
    logic           pixel_on;
    logic [3:0]     pixel_sprite_id;
    logic           fetch_busy;
    logic           fetch_done;
`ifdef SPRITE_COLLISION_EN
    logic           collision;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Sprite table as seen by the bench
    bit         tab_en [N];
    int         tab_x  [N];
    int         tab_y  [N];
    int         tab_id [N];
    int         tab_or [N];

    // Reference line buffer
    bit         m_valid [N];
    logic [7:0] m_row   [N];
    int         m_x     [N];
    int         m_id    [N];

    typedef struct {
        int x;
        bit va;
        int exp_on;
        int exp_id;
    } vec_t;

    vec_t vecs[13];

    sprite_line_fetcher #(.NUM_SPRITES(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .hblank_start    (hblank_start),
        .next_line       (next_line),
        .video_active    (video_active),
        .pixel_x         (pixel_x),
        .sprite_en       (sprite_en),
        .sprite_x        (sprite_x),
        .sprite_y        (sprite_y),
        .sprite_id       (sprite_id),
        .sprite_orient   (sprite_orient),
        .rom_sprite_ID   (rom_sprite_ID),
        .rom_orientation (rom_orientation),
        .rom_line_index  (rom_line_index),
        .rom_data        (rom_data),
        .pixel_on        (pixel_on),
        .pixel_sprite_id (pixel_sprite_id),
        .fetch_busy      (fetch_busy),
        .fetch_done      (fetch_done)
`ifdef SPRITE_COLLISION_EN
        ,
        .collision       (collision)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in sprite ROM: a few known rows, everything else a fixed scramble
    function automatic logic [7:0] rom_f(input logic [3:0] id, input logic [1:0] o, input logic [2:0] ln);
        if (id == 4'd0 && o == 2'd0 && ln == 3'd1) return 8'h99;
        if (id == 4'd1 && o == 2'd0 && ln == 3'd0) return 8'hE7;
        if (id == 4'd6 && o == 2'd0 && ln == 3'd0) return 8'h00;
        return {id[1:0], o, ln, id[2]} ^ 8'h5A;
    endfunction

    always_comb rom_data = rom_f(rom_sprite_ID, rom_orientation, rom_line_index);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic apply_table();
        for (int i = 0; i < N; i++) begin
            sprite_en[i]           = tab_en[i];
            sprite_x[i*10 +: 10]   = 10'(tab_x[i]);
            sprite_y[i*10 +: 10]   = 10'(tab_y[i]);
            sprite_id[i*4 +: 4]    = 4'(tab_id[i]);
            sprite_orient[i*2 +: 2] = 2'(tab_or[i]);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < N; i++) begin
            tab_en[i] = 0; tab_x[i] = 500 + i; tab_y[i] = 300 + i; tab_id[i] = i; tab_or[i] = 0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
    endtask

    task automatic model_fetch(input int line);
        for (int i = 0; i < N; i++) begin
            int dy = line - tab_y[i];
            m_valid[i] = tab_en[i] && dy >= 0 && dy < 8;
            m_row[i]   = rom_f(4'(tab_id[i]), 2'(tab_or[i]), 3'(dy));
            m_x[i]     = tab_x[i];
            m_id[i]    = tab_id[i];
        end
    endtask

    task automatic model_pixel(input int x, input bit va, output int on, output int id);
        on = 0;
        id = 0;
        if (va) begin
            for (int i = 0; i < N; i++) begin
                int dx = x - m_x[i];
                if (on == 0 && m_valid[i] && dx >= 0 && dx < 8 && m_row[i][7 - dx] == 1'b0) begin
                    on = 1;
                    id = m_id[i];
                end
            end
        end
    endtask

    task automatic check_pix(input string name, input int x, input bit va);
        int eon, eid;
        pixel_x      = 10'(x);
        video_active = va;
        model_pixel(x, va, eon, eid);
        tick();
        check({name, "_on"}, int'(pixel_on), eon);
        check({name, "_id"}, int'(pixel_sprite_id), eid);
    endtask

    // Full fetch with per-cycle timeline checks; leaves the bench in the cycle after DONE
    task automatic run_fetch(input int line);
        apply_table();
        next_line    = 10'(line);
        hblank_start = 1'b1;
        tick();
        hblank_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("busy_scan", int'(fetch_busy), 1);
            check("done_scan", int'(fetch_done), 0);
            check("rom_id", int'(rom_sprite_ID), tab_id[i]);
            check("rom_line", int'(rom_line_index), (line - tab_y[i]) & 7);
            tick();
        end
        check("done_pulse", int'(fetch_done), 1);
        check("busy_done", int'(fetch_busy), 0);
        tick();
        check("done_clear", int'(fetch_done), 0);
        check("rom_idle", int'(rom_sprite_ID), 15);
        model_fetch(line);
    endtask

    task automatic heart_table(input int x);
        clear_table();
        tab_en[0] = 1; tab_x[0] = x; tab_y[0] = 50; tab_id[0] = 0; tab_or[0] = 0;
    endtask

    initial begin
        reset = 1'b1; hblank_start = 1'b0; next_line = '0; video_active = 1'b0; pixel_x = '0;
        sprite_en = '0; sprite_x = '0; sprite_y = '0; sprite_id = '0; sprite_orient = '0;
        clear_table();
        model_clear();
        apply_table();

        // Reset state
        tick(); tick();
        check("rst_pixel_on", int'(pixel_on), 0);
        check("rst_pixel_id", int'(pixel_sprite_id), 0);
        check("rst_busy", int'(fetch_busy), 0);
        check("rst_done", int'(fetch_done), 0);
        check("rst_rom_id", int'(rom_sprite_ID), 15);
        check("rst_rom_or", int'(rom_orientation), 0);
        check("rst_rom_line", int'(rom_line_index), 0);
`ifdef SPRITE_COLLISION_EN
        check("rst_collision", int'(collision), 0);
`endif
        #2 reset = 1'b0;
        tick();

        // Basic row fetch, then a fixed sweep table
        heart_table(100);
        run_fetch(51);
        for (int i = 0; i < 12; i++) begin
            int x = 98 + i;
            vecs[i].x  = x;
            vecs[i].va = 1'b1;
            vecs[i].exp_on = (x == 101 || x == 102 || x == 105 || x == 106) ? 1 : 0;
            vecs[i].exp_id = 0;
        end
        vecs[12].x = 101; vecs[12].va = 1'b0; vecs[12].exp_on = 0; vecs[12].exp_id = 0;
        for (int i = 0; i < 13; i++) begin
            pixel_x      = 10'(vecs[i].x);
            video_active = vecs[i].va;
            tick();
            check($sformatf("sweep_on_x%0d", vecs[i].x), int'(pixel_on), vecs[i].exp_on);
            check($sformatf("sweep_id_x%0d", vecs[i].x), int'(pixel_sprite_id), vecs[i].exp_id);
        end
`ifdef SPRITE_COLLISION_EN
        check("no_collision_single", int'(collision), 0);
`endif

        // Vertical misses on both sides
        run_fetch(58);
        check_pix("miss_below_101", 101, 1);
        check("miss_below_direct", int'(pixel_on), 0);
        run_fetch(49);
        check_pix("miss_above_102", 102, 1);
        check("miss_above_direct", int'(pixel_on), 0);

        // Overlap priority: sword in slot 0 beats dragon head in slot 2
        clear_table();
        tab_en[0] = 1; tab_x[0] = 200; tab_y[0] = 10; tab_id[0] = 1; tab_or[0] = 0;
        tab_en[2] = 1; tab_x[2] = 200; tab_y[2] = 10; tab_id[2] = 6; tab_or[2] = 0;
        run_fetch(10);
        check_pix("overlap_203", 203, 1);
        check("overlap_203_winner", int'(pixel_sprite_id), 1);
        check_pix("overlap_200", 200, 1);
        check("overlap_200_dragon", int'(pixel_sprite_id), 6);
`ifdef SPRITE_COLLISION_EN
        check("collision_set", int'(collision), 1);
        check_pix("overlap_blank", 203, 0);
        check("collision_sticky", int'(collision), 1);
`endif

        // Restart mid-fetch with a second hblank_start at T+2
        heart_table(100);
        apply_table();
        next_line = 10'd51; hblank_start = 1'b1;
        tick();                                   // T+1
        hblank_start = 1'b0;
        check("rs_busy_t1", int'(fetch_busy), 1);
        tick();                                   // T+2
        next_line = 10'd20; hblank_start = 1'b1;
        tick();                                   // T+3
        hblank_start = 1'b0;
        check("rs_busy_t3", int'(fetch_busy), 1);
        check("rs_rom_id_t3", int'(rom_sprite_ID), tab_id[0]);
        check("rs_rom_line_t3", int'(rom_line_index), (20 - 50) & 7);
        tick(); tick();                           // T+5
        check("rs_no_done_t5", int'(fetch_done), 0);
        check("rs_busy_t5", int'(fetch_busy), 1);
        tick(); tick();                           // T+7
        check("rs_done_t7", int'(fetch_done), 1);
        tick();
        model_clear();
        model_fetch(20);
        check_pix("rs_cleared_101", 101, 1);

        // Reset mid-fetch
        run_fetch(51);
        check_pix("pre_reset_101", 101, 1);
        next_line = 10'd51; hblank_start = 1'b1;
        tick();                                   // T+1
        hblank_start = 1'b0;
        tick();                                   // T+2
        reset = 1'b1;
        #1;
        check("rm_busy", int'(fetch_busy), 0);
        check("rm_done", int'(fetch_done), 0);
        check("rm_rom_id", int'(rom_sprite_ID), 15);
        check("rm_rom_line", int'(rom_line_index), 0);
        check("rm_pixel_on", int'(pixel_on), 0);
`ifdef SPRITE_COLLISION_EN
        check("rm_collision", int'(collision), 0);
`endif
        #2 reset = 1'b0;
        model_clear();
        tick(); tick(); tick();
        check_pix("post_reset_101", 101, 1);
        check("post_reset_busy", int'(fetch_busy), 0);
        run_fetch(51);
        check_pix("refetch_101", 101, 1);
        check("refetch_on", int'(pixel_on), 1);

        // Right edge: no wrap into columns 0..3
        heart_table(1020);
        run_fetch(51);
        for (int x = 1020; x < 1024; x++) check_pix($sformatf("edge_x%0d", x), x, 1);
        for (int x = 0; x < 4; x++) check_pix($sformatf("wrap_x%0d", x), x, 1);

        // Randomized tables against the reference model
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                tab_en[i] = ($urandom_range(0, 3) != 0);
                tab_x[i]  = $urandom_range(0, 60);
                tab_y[i]  = $urandom_range(0, 20);
                tab_id[i] = $urandom_range(0, 14);
                tab_or[i] = $urandom_range(0, 3);
            end
            run_fetch($urandom_range(0, 24));
            for (int k = 0; k < 30; k++) begin
                check_pix("rand_pix", $urandom_range(0, 70), ($urandom_range(0, 7) != 0));
            end
        end

        video_active = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Per-scanline sprite fetch and pixel serialiser that sits directly downstream of the sprite ROM and upstream of the VGA colour mux. During horizontal blanking it walks a small sprite table and addresses the combinational sprite ROM once per table entry. It latches each visible sprite's 8-pixel row into a line buffer. During active video it turns the buffered rows into a registered per-pixel `pixel_on` / `pixel_sprite_id` stream for the current column.

## Interface

Parameters:
- `NUM_SPRITES`, default 4: number of sprite table entries and line-buffer slots (1..8).

Ports (packed vectors put entry i at bits `[i*W +: W]`):
- `clk`  in  1: system (pixel) clock; every register in the block is clocked on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `hblank_start`  in  1: one-cycle pulse at the start of horizontal blanking.
- `next_line`  in  10: scanline to prepare; sampled when `hblank_start` is 1.
- `video_active`  in  1: high during the visible region.
- `pixel_x`  in  10: current visible column.
- `sprite_en`  in  NUM_SPRITES: per-entry enable.
- `sprite_x`  in  NUM_SPRITES*10: top-left column of each entry.
- `sprite_y`  in  NUM_SPRITES*10: top-left row of each entry.
- `sprite_id`  in  NUM_SPRITES*4: ROM sprite ID of each entry.
- `sprite_orient`  in  NUM_SPRITES*2: ROM orientation of each entry (0 UP, 1 RIGHT, 2 DOWN, 3 LEFT).
- `rom_sprite_ID`  out  4: ROM sprite select.
- `rom_orientation`  out  2: ROM orientation select.
- `rom_line_index`  out  3: ROM row select.
- `rom_data`  in  8: ROM row, returned combinationally. It is active-low (0 = pixel on). Bit 7 is the leftmost pixel.
- `pixel_on`  out  1: registered; 1 when the current pixel is opaque for some sprite.
- `pixel_sprite_id`  out  4: registered sprite ID of the winning sprite; 0 when `pixel_on` is 0.
- `fetch_busy`  out  1: high while the block is scanning the table.
- `fetch_done`  out  1: one-cycle pulse when a scan completes.
- `collision`  out  1: present only with `SPRITE_COLLISION_EN` defined.

## Operation

- States are IDLE, SCAN and DONE.
  - IDLE moves to SCAN when `hblank_start` is 1.
  - SCAN evaluates entry `idx` each cycle. It moves to DONE after entry `NUM_SPRITES-1`.
  - DONE moves to IDLE unconditionally.
- On `hblank_start`, in any state:
  - latch `next_line`;
  - clear all slot valid bits;
  - set `idx` to 0;
  - enter SCAN.
- This means an `hblank_start` pulse during SCAN or DONE aborts the fetch and restarts it.
- During SCAN, entry `idx` is evaluated as follows:
  - `dy = line - sprite_y[idx]`, computed as an 11-bit subtraction.
  - The entry hits when `sprite_en[idx]` is 1 and `0 <= dy < 8`. There is no wrap-around: a sprite above row 0 never hits.
  - The block drives `rom_sprite_ID = sprite_id[idx]`, `rom_orientation = sprite_orient[idx]` and `rom_line_index = dy[2:0]`.
  - On a hit, at the end of the cycle, slot `idx` stores `rom_data`, `sprite_x` and `sprite_id`, and its valid bit is set to 1.
  - On a miss, the slot stays invalid.
- Sprite table inputs are read live at each entry's own SCAN cycle; they are not snapshotted at `hblank_start`.
- Outside SCAN, the ROM ports idle at `rom_sprite_ID = 4'hF` (blank tile), `rom_orientation = 0` and `rom_line_index = 0`.
- Pixel path:
  - For each valid slot, `dx = pixel_x - slot_x` (11-bit).
  - The slot is opaque when `0 <= dx < 8` and `row[7 - dx] == 0`.
  - If several slots are opaque, the lowest slot index wins.
  - When `video_active` is 0, the result is forced to `pixel_on = 0` and `pixel_sprite_id = 0`.
- The line buffer is single-banked. Callers must finish the fetch before `video_active` rises.

## Timing

- Reset values: state IDLE, all valid bits 0, `pixel_on` 0, `pixel_sprite_id` 0, `fetch_busy` 0, `fetch_done` 0, `collision` 0, ROM ports at their idle values.
- Fetch timeline, with `hblank_start` at cycle T:
  - `fetch_busy` is high from T+1 to T+NUM_SPRITES.
  - Entry i is on the ROM ports at cycle T+1+i.
  - `fetch_done` pulses at T+1+NUM_SPRITES.
  - Total fetch is NUM_SPRITES+1 cycles.
- Pixel latency is 1 cycle: `pixel_on` reflects the `pixel_x` and `video_active` values of the previous cycle.
- If a slot is written in the same cycle it is being read for pixel output, the pixel output uses the old slot contents.
- Asserting `reset` mid-SCAN immediately returns the block to its reset values. There is no partial slot write.

## Configuration

- `SPRITE_COLLISION_EN` defined:
  - `collision` is a sticky output. It is set on any active pixel where two or more valid slots are opaque.
  - It is cleared only by `reset`.
- `SPRITE_COLLISION_EN` not defined:
  - The `collision` port and its logic are absent.

## Test plan

- **Basic row fetch and pixel output.** Setup: real ROM; entry 0 = heart (id 0), UP, x=100, y=50, enabled; `next_line`=51.
  - ROM ports carry `rom_line_index`=1 at T+1 and `fetch_done` pulses at T+5 (NUM_SPRITES=4).
  - Sweeping `pixel_x` 98..109 with `video_active`=1 gives `pixel_on`=1 only for x=101, 102, 105 and 106, each one cycle later, with `pixel_sprite_id`=0.
- **Vertical miss.** Same entry with `next_line`=58 or 49.
  - No slot becomes valid.
  - `pixel_on` stays 0.
  - `fetch_busy` is still high for 4 cycles.
- **Overlap priority.** Entry 0 = sword (id 1) and entry 2 = dragon head (id 6), both at x=200, y=10; `next_line`=10.
  - At x=203, `pixel_sprite_id` is 1.
  - With `SPRITE_COLLISION_EN` defined, `collision` rises and stays at 1.
- **Restart mid-fetch.** A second `hblank_start` (with `next_line`=20) at T+2.
  - The valid bits are cleared.
  - Entry 0 is re-addressed at T+3.
  - `fetch_done` pulses at T+7, not T+5.
- **Reset mid-fetch.** Assert `reset` at T+2.
  - All outputs take their reset values in that cycle.
  - After release, `pixel_on` stays 0 at x=101 until a new fetch completes.
- **Blanking and right edge.** `video_active`=0 with x=101: `pixel_on`=0. Entry at x=1020: columns 1020..1023 render and no pixel appears at x=0..3.
